ppu_control_pipeline: RTL and testbench
=======================================

PPU_CONTROL_PIPELINE -- requirements
Module: ppu_control_pipeline

Interface
REQ-001 Parameter DATA_W, default 32: instruction width.
REQ-002 Parameter CW_W, default 17: control-word width, with the field layout defined in ppu_ctrl_pkg.
REQ-003 Parameter MD_LATENCY, default 4, legal range 1 or more: MULT busy cycles.
REQ-004 Parameter HAZARD_EN, default 1: 1 enables interlocks; 0 disables all stalls (software-scheduled code).
REQ-005 The block SHALL have one clock; reset is synchronous and active-high, with ports named clk and reset.
REQ-006 Ports SHALL be, in order:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- if_valid  in  1  instruction valid.
- instruction  in  DATA_W  instruction in ID.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- id_ready  out  1  ID consumes instruction this cycle.
- ex_ctrl, mem_ctrl, wb_ctrl  out  CW_W each  registered stage control words.
- ex_valid, mem_valid, wb_valid  out  1 each  stage holds a real instruction.
- wb_dest  out  5  write-back register index.
- md_busy  out  1  multiply unit busy.

Function
REQ-007 Control-word layout SHALL be:
- [16:14] source-operand select
- [13:11] ALU op
- [10] load
- [9] RF enable
- [8] branch
- [7] target-address
- [6:5] memory size
- [4] memory RW
- [3] memory SE
- [2] HI enable
- [1] LO enable
- [0] memory enable
REQ-008 Decode SHALL cover ADDU, SUBU, ADDIU, LUI, LBU, SB, BGTZ, JAL, JR, MULT, MFHI and MFLO; each has a fixed word in ppu_ctrl_pkg, and unknown opcodes decode as a bubble.
REQ-009 An all-zero instruction or if_valid=0 SHALL decode as a bubble: control word 0, valid 0.
REQ-010 Destination register SHALL be:
- rd for R-type;
- rt for ADDIU, LUI and LBU;
- 31 for JAL;
- 0 otherwise.
REQ-011 The pipeline SHALL have latency 1 per stage: an instruction accepted at edge N appears on ex_* after N, on mem_* after N+1, and on wb_* after N+2.
REQ-012 EX to MEM to WB SHALL advance every cycle unconditionally, with no downstream back-pressure.
REQ-013 A load-use stall SHALL occur when HAZARD_EN=1 and all of the following hold:
- ex_valid is 1;
- the EX instruction is a load;
- the EX destination is not 0;
- the EX destination equals an rs/rt source actually read by the ID instruction.
REQ-014 A multiply stall SHALL occur when HAZARD_EN=1, md_busy=1, and the ID instruction is MULT, MFHI or MFLO.
REQ-015 During a stall the block SHALL hold id_ready=0, leave the ID instruction unconsumed, and insert a bubble into EX.
REQ-016 The multiply counter width SHALL be clog2(MD_LATENCY+1).
REQ-017 The counter SHALL load MD_LATENCY on the edge a valid MULT enters EX and decrement by 1 each later cycle until it reaches 0; md_busy SHALL equal (counter != 0).
REQ-018 When ex_branch_taken=1, the ID instruction SHALL be squashed: a bubble enters EX and id_ready=1, so the instruction is discarded.
REQ-019 Flush SHALL take priority over any coincident stall.
REQ-020 The EX instruction itself SHALL never be squashed by flush.
REQ-021 A MULT entering EX while md_busy=1 SHALL be impossible when HAZARD_EN=1; when HAZARD_EN=0 it SHALL reload the counter.
REQ-022 A bubble entering EX SHALL never load the counter.

Reset
REQ-023 On reset=1 at an edge, the block SHALL clear all of the following at that edge, regardless of operation in progress:
- every *_ctrl to 0;
- every *_valid to 0;
- wb_dest to 0;
- the counter to 0, so md_busy=0.
REQ-024 While reset=1, id_ready SHALL be 0.
REQ-025 A MULT in flight at reset SHALL be abandoned.

Structure
REQ-026 Package ppu_ctrl_pkg SHALL hold:
- opcode and funct constants;
- control-word field indices;
- CW_W;
- the per-instruction control-word constants;
- the bubble constant.
REQ-027 Combinational decode (control word, dest, sources used, load/MULT/HI-LO flags) SHALL be sub-module ppu_decode; hazard logic, the stage registers and the counter SHALL reside in ppu_control_pipeline.

Verification
REQ-028 Reset, then ADDIU $8,$0,5 (0x24080005) with if_valid=1 -> ex_ctrl equals the ADDIU word on the next cycle; wb_valid=1 and wb_dest=8 two cycles later.
REQ-029 LBU $8,0($9) (0x91280000) then SUBU $10,$8,$11 (0x010B5023) -> id_ready=0 for exactly 1 cycle with ex_valid=0 (bubble), and SUBU reaches EX 2 cycles after LBU.
REQ-030 MULT $8,$9 then MFLO $10 with MD_LATENCY=4 -> md_busy high 4 cycles, MFLO stalled while md_busy=1, and MFLO reaches EX 5 cycles after MULT.
REQ-031 Load-use condition plus ex_branch_taken=1 in the same cycle -> id_ready=1, ID instruction discarded, and it never appears on ex_ctrl.
REQ-032 HAZARD_EN=0 with the REQ-029 sequence -> id_ready stays 1 and SUBU enters EX the cycle after LBU.
REQ-033 reset=1 two cycles into MULT -> after that edge, md_busy=0 and all valids=0; a following MFLO issues without a stall.

Source files
------------

// File: rtl/ppu_ctrl_pkg.sv
// Shared decode constants for the PPU control pipeline:
// opcodes, control-word field indices and per-instruction control words.
package ppu_ctrl_pkg;

    localparam int CW_W = 17;

    localparam int CW_SRC_HI  = 16;
    localparam int CW_SRC_LO  = 14;
    localparam int CW_ALU_HI  = 13;
    localparam int CW_ALU_LO  = 11;
    localparam int CW_LOAD    = 10;
    localparam int CW_RF_EN   = 9;
    localparam int CW_BRANCH  = 8;
    localparam int CW_TARGET  = 7;
    localparam int CW_SIZE_HI = 6;
    localparam int CW_SIZE_LO = 5;
    localparam int CW_MEM_RW  = 4;
    localparam int CW_MEM_SE  = 3;
    localparam int CW_HI_EN   = 2;
    localparam int CW_LO_EN   = 1;
    localparam int CW_MEM_EN  = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SB    = 6'h28;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef logic [CW_W-1:0] cw_t;

    // {src, alu, load, rf, br, tgt, size, rw, se, hi, lo, mem}
    localparam cw_t CW_ADDU  = {3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                                2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam cw_t CW_SUBU  = {3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0,
                                2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam cw_t CW_ADDIU = {3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                                2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam cw_t CW_LUI   = {3'd2, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0,
                                2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam cw_t CW_LBU   = {3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0,
                                2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam cw_t CW_SB    = {3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                                2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam cw_t CW_BGTZ  = {3'd3, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0,
                                2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam cw_t CW_JAL   = {3'd4, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1,
                                2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam cw_t CW_JR    = {3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1,
                                2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam cw_t CW_MULT  = {3'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0,
                                2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam cw_t CW_MFHI  = {3'd6, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0,
                                2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam cw_t CW_MFLO  = {3'd7, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0,
                                2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam cw_t CW_BUBBLE = '0;

endpackage

// File: rtl/ppu_decode.sv
// Combinational ID-stage decode: control word, destination,
// source usage and hazard-relevant instruction class flags.
module ppu_decode
    import ppu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              if_valid,
    input  logic [DATA_W-1:0] instruction,
    output logic [CW_W-1:0]   cw,
    output logic [4:0]        dest,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic              uses_rs,
    output logic              uses_rt,
    output logic              is_load,
    output logic              is_mult,
    output logic              is_hilo,
    output logic              valid
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rd;

    assign op    = instruction[31:26];
    assign funct = instruction[5:0];
    assign rs    = instruction[25:21];
    assign rt    = instruction[20:16];
    assign rd    = instruction[15:11];

    always_comb begin
        cw      = CW_BUBBLE;
        dest    = 5'd0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_mult = 1'b0;
        is_hilo = 1'b0;
        // All-zero word is a NOP, never a real SLL
        if (if_valid && instruction != '0) begin
            unique case (op)
                OP_RTYPE: begin
                    unique case (funct)
                        FN_ADDU: begin
                            cw = CW_ADDU; dest = rd;
                            uses_rs = 1'b1; uses_rt = 1'b1;
                        end
                        FN_SUBU: begin
                            cw = CW_SUBU; dest = rd;
                            uses_rs = 1'b1; uses_rt = 1'b1;
                        end
                        FN_JR: begin
                            cw = CW_JR; dest = rd;
                            uses_rs = 1'b1;
                        end
                        FN_MULT: begin
                            cw = CW_MULT; dest = rd;
                            uses_rs = 1'b1; uses_rt = 1'b1;
                            is_mult = 1'b1;
                        end
                        FN_MFHI: begin
                            cw = CW_MFHI; dest = rd; is_hilo = 1'b1;
                        end
                        FN_MFLO: begin
                            cw = CW_MFLO; dest = rd; is_hilo = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_ADDIU: begin
                    cw = CW_ADDIU; dest = rt; uses_rs = 1'b1;
                end
                OP_LUI: begin
                    cw = CW_LUI; dest = rt;
                end
                OP_LBU: begin
                    cw = CW_LBU; dest = rt; uses_rs = 1'b1;
                end
                OP_SB: begin
                    cw = CW_SB; uses_rs = 1'b1; uses_rt = 1'b1;
                end
                OP_BGTZ: begin
                    cw = CW_BGTZ; uses_rs = 1'b1;
                end
                OP_JAL: begin
                    cw = CW_JAL; dest = 5'd31;
                end
                default: ;
            endcase
        end
    end

    assign is_load = cw[CW_LOAD];
    assign valid   = (cw != CW_BUBBLE);

endmodule

// File: rtl/ppu_control_pipeline.sv
// ID hazard/flush control and EX/MEM/WB control-word pipeline
// with a multiply-busy countdown.
module ppu_control_pipeline #(
    parameter int DATA_W     = 32,
    parameter int CW_W       = 17,
    parameter int MD_LATENCY = 4,
    parameter int HAZARD_EN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] instruction,
    input  logic              ex_branch_taken,
    output logic              id_ready,
    output logic [CW_W-1:0]   ex_ctrl,
    output logic [CW_W-1:0]   mem_ctrl,
    output logic [CW_W-1:0]   wb_ctrl,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [4:0]        wb_dest,
    output logic              md_busy
);

    import ppu_ctrl_pkg::*;

    localparam int   CNT_W = $clog2(MD_LATENCY + 1);
    localparam logic HZ_ON = (HAZARD_EN != 0);

    logic [ppu_ctrl_pkg::CW_W-1:0] id_cw;
    logic [4:0] id_dest, id_rs, id_rt;
    logic id_uses_rs, id_uses_rt;
    logic id_is_load, id_is_mult, id_is_hilo, id_valid;

    logic [4:0] ex_dest, mem_dest;
    logic ex_load;
    logic [CNT_W-1:0] md_cnt;
    logic lu_hazard, md_hazard, stall, flush, issue;

    ppu_decode #(.DATA_W(DATA_W)) u_decode (
        .if_valid    (if_valid),
        .instruction (instruction),
        .cw          (id_cw),
        .dest        (id_dest),
        .rs          (id_rs),
        .rt          (id_rt),
        .uses_rs     (id_uses_rs),
        .uses_rt     (id_uses_rt),
        .is_load     (id_is_load),
        .is_mult     (id_is_mult),
        .is_hilo     (id_is_hilo),
        .valid       (id_valid)
    );

    always_comb begin
        lu_hazard = ex_valid && ex_load && (ex_dest != 5'd0) &&
                    ((id_uses_rs && id_rs == ex_dest) ||
                     (id_uses_rt && id_rt == ex_dest));
        md_hazard = md_busy && (id_is_mult || id_is_hilo);
        stall     = HZ_ON && (lu_hazard || md_hazard);
        flush     = ex_branch_taken;
        // Flush wins over stall: the ID word is dropped, not held
        issue     = id_valid && !stall && !flush;
        id_ready  = !reset && (flush || !stall);
    end

    assign md_busy = (md_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl   <= '0;
            mem_ctrl  <= '0;
            wb_ctrl   <= '0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
            ex_dest   <= 5'd0;
            mem_dest  <= 5'd0;
            wb_dest   <= 5'd0;
            ex_load   <= 1'b0;
            md_cnt    <= '0;
        end else begin
            ex_valid  <= issue;
            ex_ctrl   <= issue ? CW_W'(id_cw) : '0;
            ex_dest   <= issue ? id_dest : 5'd0;
            ex_load   <= issue && id_is_load;
            mem_valid <= ex_valid;
            mem_ctrl  <= ex_ctrl;
            mem_dest  <= ex_dest;
            wb_valid  <= mem_valid;
            wb_ctrl   <= mem_ctrl;
            wb_dest   <= mem_dest;
            if (issue && id_is_mult) begin
                md_cnt <= CNT_W'(MD_LATENCY);
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ppu_control_pipeline.sv
// Scoreboard bench for ppu_control_pipeline: interlocked instance
// plus a software-scheduled (no interlock) instance.
module tb_ppu_control_pipeline;

    typedef struct {
        logic [16:0] cw;
        logic [4:0]  dest;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] instruction;
    logic        ex_branch_taken;
    logic        id_ready;
    logic [16:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic        ex_valid, mem_valid, wb_valid;
    logic [4:0]  wb_dest;
    logic        md_busy;

    logic        nh_valid;
    logic [31:0] nh_instr;
    logic        nh_br;
    logic        nh_id_ready;
    logic [16:0] nh_ex_ctrl, nh_mem_ctrl, nh_wb_ctrl;
    logic        nh_ex_valid, nh_mem_valid, nh_wb_valid;
    logic [4:0]  nh_wb_dest;
    logic        nh_md_busy;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    exp_t ex_q[$];
    exp_t wb_q[$];
    exp_t me, mw;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ppu_control_pipeline #(.MD_LATENCY(4), .HAZARD_EN(1)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .if_valid        (if_valid),
        .instruction     (instruction),
        .ex_branch_taken (ex_branch_taken),
        .id_ready        (id_ready),
        .ex_ctrl         (ex_ctrl),
        .mem_ctrl        (mem_ctrl),
        .wb_ctrl         (wb_ctrl),
        .ex_valid        (ex_valid),
        .mem_valid       (mem_valid),
        .wb_valid        (wb_valid),
        .wb_dest         (wb_dest),
        .md_busy         (md_busy)
    );

    ppu_control_pipeline #(.MD_LATENCY(4), .HAZARD_EN(0)) u_nh (
        .clk             (clk),
        .reset           (reset),
        .if_valid        (nh_valid),
        .instruction     (nh_instr),
        .ex_branch_taken (nh_br),
        .id_ready        (nh_id_ready),
        .ex_ctrl         (nh_ex_ctrl),
        .mem_ctrl        (nh_mem_ctrl),
        .wb_ctrl         (nh_wb_ctrl),
        .ex_valid        (nh_ex_valid),
        .mem_valid       (nh_mem_valid),
        .wb_valid        (nh_wb_valid),
        .wb_dest         (nh_wb_dest),
        .md_busy         (nh_md_busy)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [31:0] ins, logic br);
        if_valid        = v;
        instruction     = ins;
        ex_branch_taken = br;
    endtask

    task automatic expect_ex(logic [16:0] cw, logic [4:0] dest,
                             int c, bit to_wb);
        exp_t e;
        e.cw   = cw;
        e.dest = dest;
        e.cyc  = c;
        ex_q.push_back(e);
        if (to_wb) begin
            e.cyc = c + 2;
            wb_q.push_back(e);
        end
    endtask

    // Monitor: registered outputs sampled on the falling edge
    always @(negedge clk) begin
        if (ex_valid) begin
            if (ex_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL ex_unexpected: got ctrl %h, required none",
                         ex_ctrl);
            end else begin
                me = ex_q.pop_front();
                chk("ex_ctrl", 32'(ex_ctrl), 32'(me.cw));
                chk("ex_cycle", cyc, me.cyc);
            end
        end else if (!reset) begin
            chk("ex_bubble_ctrl", 32'(ex_ctrl), 32'h0);
        end
        if (wb_valid) begin
            if (wb_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL wb_unexpected: got ctrl %h, required none",
                         wb_ctrl);
            end else begin
                mw = wb_q.pop_front();
                chk("wb_ctrl", 32'(wb_ctrl), 32'(mw.cw));
                chk("wb_dest", 32'(wb_dest), 32'(mw.dest));
                chk("wb_cycle", cyc, mw.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "timeout");
    end

    logic [31:0] s_ins [12] = '{
        32'h0C000010, 32'h3C051234, 32'hA1280000, 32'h1D200005,
        32'h03E00008, 32'h91200000, 32'h00000821, 32'h91280000,
        32'h3C080001, 32'hFC000000, 32'h00000000, 32'h00000000
    };
    logic [16:0] s_cw [12] = '{
        17'h11280, 17'h09200, 17'h04011, 17'h0D900,
        17'h15080, 17'h04601, 17'h00200, 17'h04601,
        17'h09200, 17'h00000, 17'h00000, 17'h00000
    };
    logic [4:0] s_dst [12] = '{
        5'd31, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0,
        5'd1, 5'd8, 5'd8, 5'd0, 5'd0, 5'd0
    };

    initial begin
        reset    = 1'b1;
        nh_valid = 1'b0;
        nh_instr = '0;
        nh_br    = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        step();
        step();
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_mem_valid", 32'(mem_valid), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_dest", 32'(wb_dest), 0);
        chk("rst_md_busy", 32'(md_busy), 0);
        drive(1'b1, 32'h24080005, 1'b0);
        #1;
        chk("rst_id_ready", 32'(id_ready), 0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        step();

        // ADDIU $8,$0,5
        drive(1'b1, 32'h24080005, 1'b0);
        #1;
        chk("addiu_id_ready", 32'(id_ready), 1);
        expect_ex(17'h04200, 5'd8, cyc + 1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        repeat (3) step();

        // LBU $8,0($9) ; SUBU $10,$8,$11 -> one-cycle load-use stall
        drive(1'b1, 32'h91280000, 1'b0);
        expect_ex(17'h04601, 5'd8, cyc + 1, 1'b1);
        step();
        drive(1'b1, 32'h010B5023, 1'b0);
        #1;
        chk("lu_stall_id_ready", 32'(id_ready), 0);
        step();
        chk("lu_bubble_ex_valid", 32'(ex_valid), 0);
        chk("lu_release_id_ready", 32'(id_ready), 1);
        expect_ex(17'h00A00, 5'd10, cyc + 1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        repeat (3) step();

        // MULT $8,$9 ; MFLO $10 -> held while md_busy
        drive(1'b1, 32'h01090018, 1'b0);
        expect_ex(17'h02006, 5'd0, cyc + 1, 1'b1);
        step();
        drive(1'b1, 32'h00005012, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("md_busy_high", 32'(md_busy), 1);
            chk("md_stall_id_ready", 32'(id_ready), 0);
            step();
        end
        chk("md_busy_clear", 32'(md_busy), 0);
        chk("mflo_id_ready", 32'(id_ready), 1);
        expect_ex(17'h1D200, 5'd10, cyc + 1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        repeat (3) step();

        // Load-use plus taken branch: SUBU discarded
        drive(1'b1, 32'h91280000, 1'b0);
        expect_ex(17'h04601, 5'd8, cyc + 1, 1'b1);
        step();
        drive(1'b1, 32'h010B5023, 1'b1);
        #1;
        chk("flush_id_ready", 32'(id_ready), 1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        repeat (3) step();

        // Back-to-back stream incl. dest-0 load, unknown op, NOP
        for (int i = 0; i < 12; i++) begin
            drive((i != 11), (i == 11) ? 32'h24080005 : s_ins[i], 1'b0);
            #1;
            chk("stream_id_ready", 32'(id_ready), 1);
            if (s_cw[i] != 17'h0)
                expect_ex(s_cw[i], s_dst[i], cyc + 1, 1'b1);
            step();
        end
        drive(1'b0, 32'h0, 1'b0);
        repeat (3) step();

        // Reset two cycles into a MULT
        drive(1'b1, 32'h01090018, 1'b0);
        expect_ex(17'h02006, 5'd0, cyc + 1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        step();
        reset = 1'b1;
        step();
        chk("mrst_md_busy", 32'(md_busy), 0);
        chk("mrst_ex_valid", 32'(ex_valid), 0);
        chk("mrst_mem_valid", 32'(mem_valid), 0);
        chk("mrst_wb_valid", 32'(wb_valid), 0);
        reset = 1'b0;
        drive(1'b1, 32'h00005012, 1'b0);
        #1;
        chk("mrst_mflo_ready", 32'(id_ready), 1);
        expect_ex(17'h1D200, 5'd10, cyc + 1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        repeat (3) step();

        // No-interlock instance: LBU ; SUBU issue back to back
        nh_valid = 1'b1;
        nh_instr = 32'h91280000;
        step();
        chk("nh_lbu_ex_ctrl", 32'(nh_ex_ctrl), 32'h04601);
        nh_instr = 32'h010B5023;
        #1;
        chk("nh_subu_id_ready", 32'(nh_id_ready), 1);
        step();
        chk("nh_subu_ex_ctrl", 32'(nh_ex_ctrl), 32'h00A00);
        chk("nh_subu_ex_valid", 32'(nh_ex_valid), 1);
        // MULT while busy reloads the counter
        nh_instr = 32'h01090018;
        step();
        chk("nh_mult_busy", 32'(nh_md_busy), 1);
        nh_valid = 1'b0;
        step();
        nh_valid = 1'b1;
        #1;
        chk("nh_mult2_ready", 32'(nh_id_ready), 1);
        step();
        nh_valid = 1'b0;
        repeat (3) step();
        chk("nh_reload_busy", 32'(nh_md_busy), 1);
        step();
        chk("nh_reload_done", 32'(nh_md_busy), 0);
        step();
        chk("nh_wb_dest", 32'(nh_wb_dest), 0);

        repeat (4) step();
        chk("ex_q_drained", ex_q.size(), 0);
        chk("wb_q_drained", wb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
